// File: rtl/accum_bank_if.sv
// rtl/accum_bank_if.sv - clear/write/read/overflow bus of the accumulator bank
interface accum_bank_if #(
    parameter int ADDR_W = 4,
    parameter int IN_W   = 8,
    parameter int DATA_W = 16
);
    logic              io_clear;
    logic              io_busy;
    logic              io_wr_en;
    logic              io_wr_mode;
    logic [ADDR_W-1:0] io_wr_addr;
    logic [IN_W-1:0]   io_wr_data;
    logic              io_rd_en;
    logic [ADDR_W-1:0] io_rd_addr;
    logic              io_rd_valid;
    logic [DATA_W-1:0] io_rd_data;
    logic              io_ovf;
    logic              io_ovf_clr;

    modport master (
        output io_clear, io_wr_en, io_wr_mode, io_wr_addr, io_wr_data,
               io_rd_en, io_rd_addr, io_ovf_clr,
        input  io_busy, io_rd_valid, io_rd_data, io_ovf
    );

    modport slave (
        input  io_clear, io_wr_en, io_wr_mode, io_wr_addr, io_wr_data,
               io_rd_en, io_rd_addr, io_ovf_clr,
        output io_busy, io_rd_valid, io_rd_data, io_ovf
    );
endinterface

// File: rtl/accum_bank.sv
// rtl/accum_bank.sv - signed accumulator memory with saturating adds and swept clear
module accum_bank #(
    parameter int DATA_W   = 16,
    parameter int IN_W     = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int SATURATE = 1
) (
    input logic         clock,
    input logic         reset,
    accum_bank_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] MAX_VAL   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_VAL   = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range, rd_in_range, wr_ok, ovf_hit, ovf_set;
    logic [DATA_W-1:0] cur, acc_result, wr_value;
    logic [DATA_W:0]   d_ext, sum;
    logic              rd_valid, ovf;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clock) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.io_clear) state_next = CLEAR;
            CLEAR:   if (cnt == LAST)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)               cnt <= '0;
        else if (state == CLEAR) cnt <= cnt + 1'b1;
        else                     cnt <= '0;
    end

    assign wr_in_range = ({1'b0, bus.io_wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, bus.io_rd_addr} < DEPTH_EXT);
    // A clear request in the same cycle takes priority over the write.
    assign wr_ok = (state == IDLE) && !bus.io_clear && bus.io_wr_en && wr_in_range;

    // One extra bit of headroom makes overflow a simple top-two-bit disagreement.
    assign d_ext      = {{(DATA_W+1-IN_W){bus.io_wr_data[IN_W-1]}}, bus.io_wr_data};
    assign cur        = wr_in_range ? mem[bus.io_wr_addr] : '0;
    assign sum        = {cur[DATA_W-1], cur} + d_ext;
    assign ovf_hit    = sum[DATA_W] ^ sum[DATA_W-1];
    assign acc_result = (ovf_hit && SATURATE != 0) ? (sum[DATA_W] ? MIN_VAL : MAX_VAL)
                                                    : sum[DATA_W-1:0];
    assign wr_value   = bus.io_wr_mode ? d_ext[DATA_W-1:0] : acc_result;
    assign ovf_set    = wr_ok && !bus.io_wr_mode && ovf_hit;

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) mem[cnt] <= '0;
            else if (wr_ok)     mem[bus.io_wr_addr] <= wr_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            ovf      <= 1'b0;
        end else begin
            rd_valid <= bus.io_rd_en;
            rd_data  <= (bus.io_rd_en && rd_in_range) ? mem[bus.io_rd_addr] : '0;
            if (ovf_set)             ovf <= 1'b1;
            else if (bus.io_ovf_clr) ovf <= 1'b0;
        end
    end

    assign bus.io_busy     = (state == CLEAR);
    assign bus.io_rd_valid = rd_valid;
    assign bus.io_rd_data  = rd_data;
    assign bus.io_ovf      = ovf;
endmodule

// File: tb/tb_accum_bank.sv
// tb/tb_accum_bank.sv - directed bench for accum_bank, saturating and wrapping instances
module tb_accum_bank;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    accum_bank_if #(.ADDR_W(4), .IN_W(8), .DATA_W(16)) bus_a ();
    accum_bank_if #(.ADDR_W(4), .IN_W(8), .DATA_W(16)) bus_b ();

    // The wrapping instance sees exactly the same stimulus as the saturating one.
    assign bus_b.io_clear   = bus_a.io_clear;
    assign bus_b.io_wr_en   = bus_a.io_wr_en;
    assign bus_b.io_wr_mode = bus_a.io_wr_mode;
    assign bus_b.io_wr_addr = bus_a.io_wr_addr;
    assign bus_b.io_wr_data = bus_a.io_wr_data;
    assign bus_b.io_rd_en   = bus_a.io_rd_en;
    assign bus_b.io_rd_addr = bus_a.io_rd_addr;
    assign bus_b.io_ovf_clr = bus_a.io_ovf_clr;

    accum_bank #(.DATA_W(16), .IN_W(8), .DEPTH(16), .SATURATE(1)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave)
    );
    accum_bank #(.DATA_W(16), .IN_W(8), .DEPTH(16), .SATURATE(0)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b.slave)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic mode, input logic [3:0] addr, input logic [7:0] data);
        bus_a.io_wr_en   = 1'b1;
        bus_a.io_wr_mode = mode;
        bus_a.io_wr_addr = addr;
        bus_a.io_wr_data = data;
    endtask

    task automatic rd(input logic [3:0] addr);
        bus_a.io_rd_en   = 1'b1;
        bus_a.io_rd_addr = addr;
    endtask

    task automatic idle_inputs();
        bus_a.io_clear   = 1'b0;
        bus_a.io_wr_en   = 1'b0;
        bus_a.io_wr_mode = 1'b0;
        bus_a.io_wr_addr = '0;
        bus_a.io_wr_data = '0;
        bus_a.io_rd_en   = 1'b0;
        bus_a.io_rd_addr = '0;
        bus_a.io_ovf_clr = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus_a.io_busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        chk("reset_rd_valid", 32'(bus_a.io_rd_valid), 32'd0);
        chk("reset_rd_data", 32'(bus_a.io_rd_data), 32'd0);
        chk("reset_ovf", 32'(bus_a.io_ovf), 32'd0);
        reset = 1'b0;
        count_busy(n);
        chk("post_reset_busy_cycles", 32'(n), 32'd16);

        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            step();
            chk($sformatf("swept_valid_%0d", i), 32'(bus_a.io_rd_valid), 32'd1);
            chk($sformatf("swept_data_%0d", i), 32'(bus_a.io_rd_data), 32'd0);
        end
        bus_a.io_rd_en = 1'b0;
        step();
        chk("no_read_valid", 32'(bus_a.io_rd_valid), 32'd0);
        chk("no_read_data", 32'(bus_a.io_rd_data), 32'd0);

        wr(1'b0, 4'd4, 8'd5);   step();
        wr(1'b0, 4'd4, 8'd7);   step();
        wr(1'b0, 4'd4, 8'hFD);  step();
        bus_a.io_wr_en = 1'b0;
        rd(4'd4);               step();
        chk("acc_chain", 32'(bus_a.io_rd_data), 32'd9);
        bus_a.io_rd_en = 1'b0;
        wr(1'b1, 4'd4, 8'hFE);  step();
        bus_a.io_wr_en = 1'b0;
        rd(4'd4);               step();
        chk("overwrite_neg", 32'(bus_a.io_rd_data), 32'hFFFE);
        bus_a.io_rd_en = 1'b0;

        // 113 + 257*127 = 0x7FF0 without overflowing on the way.
        wr(1'b1, 4'd15, 8'd113); step();
        wr(1'b0, 4'd15, 8'd127);
        for (int i = 0; i < 257; i++) step();
        chk("pre_ovf_a", 32'(bus_a.io_ovf), 32'd0);
        chk("pre_ovf_b", 32'(bus_b.io_ovf), 32'd0);
        step();
        bus_a.io_wr_en = 1'b0;
        chk("pos_ovf_a", 32'(bus_a.io_ovf), 32'd1);
        chk("pos_ovf_b", 32'(bus_b.io_ovf), 32'd1);
        rd(4'd15);              step();
        chk("pos_sat_a", 32'(bus_a.io_rd_data), 32'h7FFF);
        chk("pos_wrap_b", 32'(bus_b.io_rd_data), 32'h806F);
        bus_a.io_rd_en = 1'b0;
        bus_a.io_ovf_clr = 1'b1;
        wr(1'b0, 4'd15, 8'd1);  step();
        bus_a.io_wr_en = 1'b0;
        chk("set_wins_a", 32'(bus_a.io_ovf), 32'd1);
        chk("clr_no_set_b", 32'(bus_b.io_ovf), 32'd0);
        step();
        bus_a.io_ovf_clr = 1'b0;
        chk("ovf_clr_a", 32'(bus_a.io_ovf), 32'd0);

        wr(1'b1, 4'd13, 8'h80); step();
        wr(1'b0, 4'd13, 8'h80);
        for (int i = 0; i < 255; i++) step();
        chk("min_exact_ovf_a", 32'(bus_a.io_ovf), 32'd0);
        wr(1'b0, 4'd13, 8'hFF); step();
        bus_a.io_wr_en = 1'b0;
        chk("neg_ovf_a", 32'(bus_a.io_ovf), 32'd1);
        chk("neg_ovf_b", 32'(bus_b.io_ovf), 32'd1);
        rd(4'd13);              step();
        chk("neg_sat_a", 32'(bus_a.io_rd_data), 32'h8000);
        chk("neg_wrap_b", 32'(bus_b.io_rd_data), 32'h7FFF);
        bus_a.io_rd_en = 1'b0;
        bus_a.io_ovf_clr = 1'b1; step();
        bus_a.io_ovf_clr = 1'b0;
        chk("ovf_clr_b", 32'(bus_b.io_ovf), 32'd0);

        wr(1'b1, 4'd2, 8'd10);  step();
        wr(1'b0, 4'd2, 8'd1);
        rd(4'd2);               step();
        bus_a.io_wr_en = 1'b0;
        chk("rw_same_old", 32'(bus_a.io_rd_data), 32'd10);
        step();
        chk("rw_next_new", 32'(bus_a.io_rd_data), 32'd11);
        bus_a.io_rd_en = 1'b0;

        wr(1'b1, 4'd0, 8'd3);   step();
        wr(1'b1, 4'd0, 8'd9);
        bus_a.io_clear = 1'b1;  step();
        bus_a.io_clear = 1'b0;
        // Entry 15 holds 0x7FFF in dut_a; a leaked accumulate would raise io_ovf.
        wr(1'b0, 4'd15, 8'd127);
        n = 0;
        while (bus_a.io_busy === 1'b1 && n < 40) begin
            n++;
            bus_a.io_clear = (n == 5);
            if (n == 1) rd(4'd0);
            if (n == 2) begin
                chk("clear_read_old", 32'(bus_a.io_rd_data), 32'd3);
                bus_a.io_rd_en = 1'b0;
            end
            step();
        end
        idle_inputs();
        chk("clear_busy_cycles", 32'(n), 32'd16);
        chk("busy_write_dropped", 32'(bus_a.io_ovf), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            step();
            chk($sformatf("cleared_data_%0d", i), 32'(bus_a.io_rd_data), 32'd0);
        end
        bus_a.io_rd_en = 1'b0;

        bus_a.io_clear = 1'b1;  step();
        bus_a.io_clear = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("mid_sweep_busy", 32'(bus_a.io_busy), 32'd1);
        reset = 1'b1;           step();
        reset = 1'b0;
        count_busy(n);
        chk("restart_busy_cycles", 32'(n), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
